// File: rtl/spw_tx_fifo.sv
// spw_tx_fifo: host-to-SpaceWire transmit FIFO (RAM + output register) released by the tx_ready handshake.
// Optional stored-packet counter enabled by defining SPW_TX_FIFO_PKTCNT_EN.
module spw_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int LW = $clog2(DEPTH) + 1
) (
    input  logic          pclk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [8:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          overflow,
    input  logic          link_run,
    input  logic          tx_ready,
    output logic          tx_write,
    output logic [8:0]    tx_data,
    output logic [LW-1:0] pkt_count
);
    localparam int PW = $clog2(DEPTH - 1);

    logic [8:0]    ram [DEPTH-1];
    logic [PW-1:0] wp, rp;
    logic [LW-1:0] ram_cnt;
    logic          out_valid;
    logic [8:0]    out_reg;
    logic          xfer, wr_acc, ram_empty, bypass, load, ram_wr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 2)) ? '0 : p + 1'b1;
    endfunction

    assign full      = level == LW'(DEPTH);
    assign empty     = level == '0;
    assign tx_write  = out_valid && link_run;
    assign tx_data   = out_reg;
    assign xfer      = tx_write && tx_ready;
    assign wr_acc    = wr_en && !full;
    assign ram_empty = ram_cnt == '0;
    // An empty output register implies an empty RAM, so a refill from RAM only follows a transfer.
    assign load      = xfer && !ram_empty;
    assign bypass    = wr_acc && ram_empty && (!out_valid || xfer);
    assign ram_wr    = wr_acc && !bypass;

    always_ff @(posedge pclk) begin
        if (ram_wr)
            ram[wp] <= wr_data;
    end

    always_ff @(posedge pclk) begin
        if (!resetn || flush) begin
            wp        <= '0;
            rp        <= '0;
            ram_cnt   <= '0;
            out_valid <= 1'b0;
            out_reg   <= '0;
            level     <= '0;
            overflow  <= 1'b0;
        end else begin
            if (ram_wr)
                wp <= nxt(wp);
            if (load)
                rp <= nxt(rp);
            ram_cnt <= ram_cnt + LW'(ram_wr) - LW'(load);
            if (bypass || load) begin
                out_valid <= 1'b1;
                out_reg   <= load ? ram[rp] : wr_data;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            level <= level + LW'(wr_acc) - LW'(xfer);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

`ifdef SPW_TX_FIFO_PKTCNT_EN
    logic [LW-1:0] pkt;

    always_ff @(posedge pclk) begin
        if (!resetn || flush)
            pkt <= '0;
        else
            pkt <= pkt + LW'(wr_acc && wr_data[8]) - LW'(xfer && out_reg[8]);
    end

    assign pkt_count = pkt;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_spw_tx_fifo.sv
// tb_spw_tx_fifo: directed and random stimulus for spw_tx_fifo checked against a queue-based model.
module tb_spw_tx_fifo;
    localparam int DEPTH = 16;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          pclk = 1'b0;
    logic          resetn, flush, wr_en, link_run, tx_ready;
    logic [8:0]    wr_data;
    logic          full, empty, overflow, tx_write;
    logic [LW-1:0] level, pkt_count;
    logic [8:0]    tx_data;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] q[$];
    logic       ovf = 1'b0;

    always #5 pclk = ~pclk;

    spw_tx_fifo #(.DEPTH(DEPTH)) dut (
        .pclk(pclk), .resetn(resetn), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .link_run(link_run), .tx_ready(tx_ready), .tx_write(tx_write), .tx_data(tx_data),
        .pkt_count(pkt_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_pkt();
        int n = 0;
`ifdef SPW_TX_FIFO_PKTCNT_EN
        foreach (q[i]) n += int'(q[i][8]);
`endif
        return n;
    endfunction

    task automatic check_all();
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("overflow", 32'(overflow), 32'(ovf));
        chk("tx_write", 32'(tx_write), 32'(q.size() > 0 && link_run));
        if (q.size() > 0)
            chk("tx_data", 32'(tx_data), 32'(q[0]));
        chk("pkt_count", 32'(pkt_count), 32'(exp_pkt()));
    endtask

    // Drive one cycle's inputs, advance the model at the edge, check at the following negedge.
    task automatic step(input logic we, input logic [8:0] d, input logic lr, input logic tr,
                        input logic fl = 1'b0, input logic rn = 1'b1);
        logic x, a;
        wr_en = we; wr_data = d; link_run = lr; tx_ready = tr; flush = fl; resetn = rn;
        @(posedge pclk);
        if (!rn || fl) begin
            q.delete();
            ovf = 1'b0;
        end else begin
            x = q.size() > 0 && lr && tr;
            a = we && q.size() < DEPTH;
            if (we && !a) ovf = 1'b1;
            if (x) void'(q.pop_front());
            if (a) q.push_back(d);
        end
        @(negedge pclk);
        check_all();
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; link_run = 1'b0; tx_ready = 1'b0;
        @(negedge pclk);
        step(0, 0, 0, 0, 0, 0);
        chk("reset_tx_data", 32'(tx_data), 32'h0);
        step(0, 0, 1, 0);
        step(1, 9'h041, 1, 0);
        chk("first_word", 32'(tx_data), 32'h041);
        chk("first_write", 32'(tx_write), 32'h1);

        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 9'(i), 1, 0);
        chk("full_after_fill", 32'(full), 32'h1);
        step(1, 9'h0AA, 1, 0);
        chk("overflow_set", 32'(overflow), 32'h1);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 1);
        chk("drained", 32'(empty), 32'h1);

        for (int i = 0; i < 50; i++) step(1, 9'($urandom_range(0, 511)), 1, 1);
        for (int i = 0; i < 20; i++) step(1, 9'($urandom_range(0, 511)), !(i >= 8 && i < 13), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);

        for (int i = 0; i < DEPTH; i++) step(1, 9'($urandom_range(0, 511)), 1, 0);
        step(1, 9'h0AA, 1, 0);
        for (int i = 0; i < DEPTH - 7; i++) step(0, 0, 1, 1);
        chk("level_before_flush", 32'(level), 32'd7);
        step(0, 0, 1, 0, 1);
        chk("flush_ovf", 32'(overflow), 32'h0);
        step(1, 9'h055, 1, 0);
        chk("post_flush_word", 32'(tx_data), 32'h055);
        step(0, 0, 1, 1);

        for (int i = 0; i < 3; i++) step(1, 9'($urandom_range(0, 255)), 1, 0);
        step(1, 9'h100, 1, 0);
        for (int i = 0; i < 2; i++) step(1, 9'($urandom_range(0, 255)), 1, 0);
        step(1, 9'h101, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1);
        step(1, 9'h100, 1, 0);
        step(1, 9'h1FF, 1, 1);
        step(0, 0, 1, 1);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom_range(0, 7) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
